// File: rtl/regfile_pkg.sv
// Shared definitions for the regfile_sb register file slice.
// Contents:
//   DW_DEF, DEPTH_DEF, NRD_DEF : default parameter values
//   calc_aw()                  : address width for a given register count
//   ZERO_REG                   : index of the hardwired-zero register
package regfile_pkg;

  localparam int DW_DEF    = 32;
  localparam int DEPTH_DEF = 32;
  localparam int NRD_DEF   = 2;

  // Index of the register that always reads 0 and is never busy.
  localparam int ZERO_REG  = 0;

  // DEPTH is a power of two and at least 2, so the result is always >= 1.
  function automatic int calc_aw(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// Bus bundle between the datapath (master) and the register file (slave).
// Signals:
//   wr_en/wr_addr/wr_data    : writeback commit
//   issue_en/issue_addr      : destination marked busy at dispatch
//   rd_addr                  : NRD packed read addresses, port p at [p*AW +: AW]
//   rd_data/rd_busy          : registered read data / busy flag per port
//   busy_vec                 : registered scoreboard, bit i = register i busy
//   err_waw                  : sticky issue-to-busy-register flag
interface regfile_sb_if
  import regfile_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int NRD   = NRD_DEF
);

  localparam int AW = calc_aw(DEPTH);

  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [DW-1:0]     wr_data;
  logic              issue_en;
  logic [AW-1:0]     issue_addr;
  logic [NRD*AW-1:0] rd_addr;
  logic [NRD*DW-1:0] rd_data;
  logic [NRD-1:0]    rd_busy;
  logic [DEPTH-1:0]  busy_vec;
  logic              err_waw;

  modport master (
    output wr_en, wr_addr, wr_data, issue_en, issue_addr, rd_addr,
    input  rd_data, rd_busy, busy_vec, err_waw
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, issue_en, issue_addr, rd_addr,
    output rd_data, rd_busy, busy_vec, err_waw
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard with sticky write-after-write error flag.
// Ports:
//   clk, nrst            : clock, synchronous active-low reset
//   wr_en, wr_addr       : writeback, clears the busy bit of wr_addr
//   issue_en, issue_addr : dispatch, sets the busy bit of issue_addr
//   busy_q               : registered scoreboard
//   busy_nxt             : scoreboard as it will be after this edge
//   err_waw              : sticky, set on issue to an already-busy register
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       nrst,
  input  logic                       wr_en,
  input  logic [calc_aw(DEPTH)-1:0]  wr_addr,
  input  logic                       issue_en,
  input  logic [calc_aw(DEPTH)-1:0]  issue_addr,
  output logic [DEPTH-1:0]           busy_q,
  output logic [DEPTH-1:0]           busy_nxt,
  output logic                       err_waw
);

  localparam int            AW        = calc_aw(DEPTH);
  localparam logic [AW-1:0] ZERO_ADDR = AW'(ZERO_REG);

  logic [DEPTH-1:0] busy_d;
  logic             err_d;
  logic             err_q;
  logic             wr_clr;
  logic             iss_set;

  always_comb begin
    wr_clr  = wr_en    && (wr_addr    != ZERO_ADDR);
    iss_set = issue_en && (issue_addr != ZERO_ADDR);

    // Clear first, then set: an issue and a write to the same register on
    // the same edge leave it busy (the new producer is still in flight).
    busy_d = busy_q;
    if (wr_clr)  busy_d[wr_addr]    = 1'b0;
    if (iss_set) busy_d[issue_addr] = 1'b1;
    busy_d[ZERO_REG] = 1'b0;

    // A write retiring the old producer on the same edge makes the
    // re-issue legal.
    err_d = err_q;
    if (iss_set && busy_q[issue_addr] && !(wr_clr && (wr_addr == issue_addr)))
      err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      busy_q <= '0;
      err_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      err_q  <= err_d;
    end
  end

  assign busy_nxt = busy_d;
  assign err_waw  = err_q;

endmodule

// File: rtl/regfile_sb.sv
// Parametrised multi-port register file with registered reads, write-to-read
// bypass and a per-register busy scoreboard.
// Ports:
//   clk  : clock, all state updates on the rising edge
//   nrst : synchronous active-low reset, clears array, scoreboard and outputs
//   bus  : regfile_sb_if slave (write, issue, NRD read ports, scoreboard view)
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int NRD   = NRD_DEF
) (
  input  logic         clk,
  input  logic         nrst,
  regfile_sb_if.slave  bus
);

  localparam int            AW        = calc_aw(DEPTH);
  localparam logic [AW-1:0] ZERO_ADDR = AW'(ZERO_REG);

  logic [DW-1:0]    mem_d [DEPTH];
  logic [DW-1:0]    mem_q [DEPTH];
  logic             wr_hit;
  logic [DEPTH-1:0] sb_busy_q;
  logic [DEPTH-1:0] sb_busy_nxt;
  logic             sb_err_waw;

  // Storage array; register 0 is never written so it stays at its reset 0.
  always_comb begin
    wr_hit = bus.wr_en && (bus.wr_addr != ZERO_ADDR);
    mem_d  = mem_q;
    if (wr_hit) mem_d[bus.wr_addr] = bus.wr_data;
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      mem_q <= '{default: '0};
    end else begin
      mem_q <= mem_d;
    end
  end

  regfile_scoreboard #(
    .DEPTH (DEPTH)
  ) u_scoreboard (
    .clk        (clk),
    .nrst       (nrst),
    .wr_en      (bus.wr_en),
    .wr_addr    (bus.wr_addr),
    .issue_en   (bus.issue_en),
    .issue_addr (bus.issue_addr),
    .busy_q     (sb_busy_q),
    .busy_nxt   (sb_busy_nxt),
    .err_waw    (sb_err_waw)
  );

  assign bus.busy_vec = sb_busy_q;
  assign bus.err_waw  = sb_err_waw;

  // Read ports: zero register, then bypass of this edge's write, then array.
  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [AW-1:0] addr;
    logic [DW-1:0] data_d;
    logic [DW-1:0] data_q;
    logic          busy_d;
    logic          busy_q;

    assign addr = bus.rd_addr[p*AW +: AW];

    always_comb begin
      data_d = mem_q[addr];
      if (addr == ZERO_ADDR) begin
        data_d = '0;
      end else if (bus.wr_en && (bus.wr_addr == addr)) begin
        data_d = bus.wr_data;
      end
      // Busy as seen after this edge's clear/set, so a read at the
      // retiring write's edge already reports the register free.
      busy_d = sb_busy_nxt[addr];
    end

    always_ff @(posedge clk) begin
      if (!nrst) begin
        data_q <= '0;
        busy_q <= 1'b0;
      end else begin
        data_q <= data_d;
        busy_q <= busy_d;
      end
    end

    assign bus.rd_data[p*DW +: DW] = data_q;
    assign bus.rd_busy[p]          = busy_q;
  end

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;

  logic clk  = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  regfile_sb_if #(.DW(32), .DEPTH(32), .NRD(2)) d_if ();
  regfile_sb_if #(.DW(16), .DEPTH(8),  .NRD(3)) s_if ();

  regfile_sb #(.DW(32), .DEPTH(32), .NRD(2)) u_dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (d_if.slave)
  );

  regfile_sb #(.DW(16), .DEPTH(8), .NRD(3)) u_small (
    .clk  (clk),
    .nrst (nrst),
    .bus  (s_if.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model of the default-parameter instance: plain arrays updated
  // from the architectural rules once per rising edge.
  logic [31:0] m_mem   [32];
  bit          m_busy  [32];
  bit          m_err;
  logic [31:0] m_rd    [2];
  bit          m_rbusy [2];
  bit          m_valid = 1'b0;

  always @(posedge clk) begin : model
    logic [31:0] nmem [32];
    bit          nbusy [32];
    bit          nerr;
    logic [31:0] nrd [2];
    bit          nrb [2];
    int          ra [2];
    int          wa, ia;
    bit          wr, iss;
    for (int p = 0; p < 2; p++) ra[p] = int'(d_if.rd_addr[p*5 +: 5]);
    if (!nrst) begin
      for (int i = 0; i < 32; i++) begin
        nmem[i]  = '0;
        nbusy[i] = 1'b0;
      end
      nerr = 1'b0;
      for (int p = 0; p < 2; p++) begin
        nrd[p] = '0;
        nrb[p] = 1'b0;
      end
    end else begin
      nmem  = m_mem;
      nbusy = m_busy;
      nerr  = m_err;
      wa  = int'(d_if.wr_addr);
      ia  = int'(d_if.issue_addr);
      wr  = d_if.wr_en && (wa != 0);
      iss = d_if.issue_en && (ia != 0);
      for (int p = 0; p < 2; p++) begin
        if (ra[p] == 0)              nrd[p] = '0;
        else if (wr && wa == ra[p])  nrd[p] = d_if.wr_data;
        else                         nrd[p] = m_mem[ra[p]];
      end
      if (iss && m_busy[ia] && !(wr && wa == ia)) nerr = 1'b1;
      if (wr) begin
        nmem[wa]  = d_if.wr_data;
        nbusy[wa] = 1'b0;
      end
      if (iss) nbusy[ia] = 1'b1;
      for (int p = 0; p < 2; p++) nrb[p] = nbusy[ra[p]];
    end
    m_mem   <= nmem;
    m_busy  <= nbusy;
    m_err   <= nerr;
    m_rd    <= nrd;
    m_rbusy <= nrb;
    m_valid <= m_valid | !nrst;
  end

  // Compare the default instance against the model on every falling edge.
  always @(negedge clk) begin : compare
    logic [31:0] bv;
    if (m_valid) begin
      for (int i = 0; i < 32; i++) bv[i] = m_busy[i];
      chk("rd_data0", 64'(d_if.rd_data[31:0]),  64'(m_rd[0]));
      chk("rd_data1", 64'(d_if.rd_data[63:32]), 64'(m_rd[1]));
      chk("rd_busy0", 64'(d_if.rd_busy[0]),     64'(m_rbusy[0]));
      chk("rd_busy1", 64'(d_if.rd_busy[1]),     64'(m_rbusy[1]));
      chk("busy_vec", 64'(d_if.busy_vec),       64'(bv));
      chk("err_waw",  64'(d_if.err_waw),        64'(m_err));
    end
  end

  task automatic drv(input logic wr, input logic [4:0] wa, input logic [31:0] wd,
                     input logic iss, input logic [4:0] ia,
                     input logic [4:0] r0, input logic [4:0] r1);
    d_if.wr_en      = wr;
    d_if.wr_addr    = wa;
    d_if.wr_data    = wd;
    d_if.issue_en   = iss;
    d_if.issue_addr = ia;
    d_if.rd_addr    = {r1, r0};
  endtask

  // Advance past one rising edge; outputs are sampled after the falling edge.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  initial begin
    s_if.wr_en      = 1'b0;
    s_if.wr_addr    = '0;
    s_if.wr_data    = '0;
    s_if.issue_en   = 1'b0;
    s_if.issue_addr = '0;
    s_if.rd_addr    = '0;

    // Reset dominates a concurrent write.
    nrst = 1'b0;
    drv(1, 5'd5, 32'hDEADBEEF, 0, 0, 5'd5, 5'd0);
    tick();
    tick();
    nrst = 1'b1;
    drv(0, 0, 0, 0, 0, 5'd5, 5'd0);
    tick();
    chk("lit_reset_rd0",   64'(d_if.rd_data[31:0]), 64'h0);
    chk("lit_reset_busy",  64'(d_if.busy_vec),      64'h0);
    chk("lit_reset_err",   64'(d_if.err_waw),       64'h0);
    chk("lit_small_reset", 64'(s_if.rd_data),       64'h0);

    // Write then read on both ports; small instance written in parallel.
    drv(1, 5'd7, 32'h12345678, 0, 0, 5'd0, 5'd0);
    s_if.wr_en   = 1'b1;
    s_if.wr_addr = 3'd7;
    s_if.wr_data = 16'hBEEF;
    s_if.rd_addr = {3'd7, 3'd0, 3'd7};
    tick();
    drv(0, 0, 0, 0, 0, 5'd7, 5'd7);
    s_if.wr_en = 1'b0;
    tick();
    chk("lit_r7_port0", 64'(d_if.rd_data[31:0]),  64'h12345678);
    chk("lit_r7_port1", 64'(d_if.rd_data[63:32]), 64'h12345678);
    chk("lit_small_p0", 64'(s_if.rd_data[15:0]),  64'hBEEF);
    chk("lit_small_p1", 64'(s_if.rd_data[31:16]), 64'h0);
    chk("lit_small_p2", 64'(s_if.rd_data[47:32]), 64'hBEEF);

    // Zero register ignores writes.
    drv(1, 5'd0, 32'hFFFFFFFF, 0, 0, 5'd0, 5'd7);
    tick();
    drv(0, 0, 0, 0, 0, 5'd0, 5'd0);
    tick();
    chk("lit_r0_read", 64'(d_if.rd_data[31:0]), 64'h0);

    // Bypass: write and read the same register at one edge.
    drv(1, 5'd9, 32'hA5A5A5A5, 0, 0, 5'd0, 5'd9);
    tick();
    chk("lit_bypass", 64'(d_if.rd_data[63:32]), 64'hA5A5A5A5);

    // Scoreboard set by issue, cleared by write; read at the write edge.
    drv(0, 0, 0, 1, 5'd3, 5'd0, 5'd0);
    tick();
    drv(0, 0, 0, 0, 0, 5'd3, 5'd0);
    tick();
    chk("lit_r3_busy",    64'(d_if.rd_busy[0]),   64'h1);
    chk("lit_r3_busyvec", 64'(d_if.busy_vec[3]),  64'h1);
    drv(1, 5'd3, 32'h00000033, 0, 0, 5'd3, 5'd0);
    tick();
    chk("lit_r3_clr_busy", 64'(d_if.rd_busy[0]),     64'h0);
    chk("lit_r3_clr_data", 64'(d_if.rd_data[31:0]),  64'h33);
    chk("lit_r3_clr_vec",  64'(d_if.busy_vec[3]),    64'h0);

    // Issue and write together: issue wins, data still lands.
    drv(1, 5'd4, 32'h00000044, 1, 5'd4, 5'd0, 5'd0);
    tick();
    chk("lit_r4_busy", 64'(d_if.busy_vec[4]), 64'h1);
    drv(0, 0, 0, 0, 0, 5'd4, 5'd0);
    tick();
    chk("lit_r4_data", 64'(d_if.rd_data[31:0]), 64'h44);
    chk("lit_no_err",  64'(d_if.err_waw),       64'h0);
    drv(0, 0, 0, 1, 5'd4, 5'd0, 5'd0);
    tick();
    chk("lit_waw_set", 64'(d_if.err_waw), 64'h1);
    drv(1, 5'd4, 32'h00000045, 0, 0, 5'd0, 5'd0);
    tick();
    chk("lit_waw_sticky", 64'(d_if.err_waw),     64'h1);
    chk("lit_r4_cleared", 64'(d_if.busy_vec[4]), 64'h0);

    // Randomized traffic with a narrow address range to force collisions
    // and occasional mid-stream resets.
    for (int c = 0; c < 3000; c++) begin
      logic [4:0] a [4];
      for (int k = 0; k < 4; k++)
        a[k] = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31))
                                           : 5'($urandom_range(0, 6));
      nrst = ($urandom_range(0, 149) != 0);
      drv(1'($urandom_range(0, 1)), a[0], $urandom,
          1'($urandom_range(0, 2) == 0), a[1], a[2],
          ($urandom_range(0, 4) == 0) ? a[2] : a[3]);
      tick();
    end
    nrst = 1'b1;
    drv(0, 0, 0, 0, 0, 0, 0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised multi-port register file with registered reads, write-to-read bypass and a per-register busy scoreboard. It replaces the fixed 32×32, two-read-port register file in the pipelined datapath. Decode uses it to fetch operands and to detect RAW hazards on destinations still in flight. Writeback uses it to commit results.

## Interface
Parameters:
- DW, 32, data width in bits (≥1)
- DEPTH, 32, number of registers (power of two, ≥2); localparam AW = $clog2(DEPTH)
- NRD, 2, number of read ports (≥1)

Ports:
- clk  in  1  clock; all state updates on rising edge
- nrst  in  1  reset, synchronous, active-low
- wr_en  in  1  commit write this cycle
- wr_addr  in  AW  write destination
- wr_data  in  DW  write value
- issue_en  in  1  mark issue_addr busy (instruction dispatched)
- issue_addr  in  AW  destination being issued
- rd_addr  in  NRD*AW  read addresses; port p occupies bits [p*AW +: AW]
- rd_data  out  NRD*DW  registered read data; port p occupies bits [p*DW +: DW]
- rd_busy  out  NRD  registered busy flag per read port
- busy_vec  out  DEPTH  current scoreboard, bit i = register i busy
- err_waw  out  1  sticky: issue to an already-busy register

## Operation
- **Storage.** DEPTH×DW array.
  - Register 0 is hardwired: reads return 0.
  - Register 0 is never busy.
  - wr_en and issue_en targeting address 0 are ignored.
- **Reset.** With nrst=0 at an edge:
  - all array entries go to 0;
  - busy_vec, rd_data, rd_busy and err_waw go to 0.
  - Reset dominates wr_en and issue_en in the same cycle.
- **Write.**
  - wr_en=1 and wr_addr≠0 at an edge: mem[wr_addr] ← wr_data.
  - The same edge clears busy[wr_addr].
- **Issue.**
  - issue_en=1 and issue_addr≠0 at an edge: busy[issue_addr] ← 1.
  - Issue and write to the same address in the same cycle: issue wins and the register stays busy. The data is still written.
- **Read (each port p, every cycle, no enable).**
  - At each edge, rd_data[p] ← 0 if rd_addr[p]=0.
  - Else rd_data[p] ← wr_data if wr_en=1 and wr_addr=rd_addr[p] (bypass).
  - Otherwise rd_data[p] ← mem[rd_addr[p]].
- **Read busy.** rd_busy[p] ← the next-state busy bit of rd_addr[p], i.e. after this edge's write clear and issue set.
- **WAW error.**
  - err_waw ← 1 when issue_en=1, issue_addr≠0, busy[issue_addr]=1, and the same edge does not clear it (no wr_en to that address).
  - err_waw stays 1 until reset.
- **Port independence.**
  - Multiple read ports may use the same address; each gets identical data.
  - No read/write ordering hazard exists beyond the bypass rule.

## Timing
- Read latency is 1 cycle: address presented before edge k gives data and busy valid after edge k, held until edge k+1.
- The write is visible in the array after its edge. A read sampled at that same edge sees the new value via bypass, so there is no stale-read window.
- busy_vec is the registered scoreboard, updated at the edge, with no combinational path from inputs.
- Reset mid-operation: a pending write in the reset cycle is discarded. Outputs read 0 one edge after nrst is sampled low. Normal operation resumes at the first edge with nrst=1.
- Ports never stall. There is no handshake: every asserted wr_en and issue_en is consumed at the edge.

## Structure
- Package regfile_pkg holds:
  - default parameter constants (DW_DEF=32, DEPTH_DEF=32, NRD_DEF=2);
  - the AW computation function;
  - the ZERO_REG address constant.
- Sub-module regfile_scoreboard (parameter DEPTH) holds:
  - the busy bits;
  - the issue/clear priority logic;
  - the err_waw sticky flag;
  - a next-state busy output, which the top uses for rd_busy.
- The top level instantiates the array, the NRD read muxes with bypass (generate loop), and the scoreboard.

## Test plan
1. **Reset.** Default params. Drive nrst=0 for 2 edges with wr_en=1, wr_addr=5, wr_data=0xDEADBEEF; then read port 0 addr 5 → rd_data[0]=0, busy_vec=0, err_waw=0.
2. **Write then read, zero register.** Write 0x12345678 to r7; next cycle read r7 on both ports → both return 0x12345678 after one edge. Write 0xFFFFFFFF to r0, read r0 → 0.
3. **Bypass.** In a single cycle write 0xA5A5A5A5 to r9 and read r9 on port 1 → rd_data[1]=0xA5A5A5A5 after that edge.
4. **Scoreboard.** Issue r3, then read r3 → rd_busy=1 and busy_vec[3]=1. Write r3 → busy clears. A read sampled at the write edge returns rd_busy=0 plus the new data.
5. **Simultaneous issue/write and WAW.**
   - Issue and write r4 at the same edge → busy_vec[4]=1, data written.
   - Issue r4 again with no write → err_waw=1, and it remains 1 after clearing r4.
6. **Parametrisation.** DW=16, DEPTH=8, NRD=3: write r7=0xBEEF, read r7/r0/r7 on ports 0-2 → 0xBEEF/0/0xBEEF. Address widths are 3 bits.
